pc_sequencer: RTL

//   Parametrised program-counter sequencer for the single-cycle datapath fetch stage.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// Fetch-stage PC sequencer: RESET->LOAD->RUN/HALT FSM with stall/jump/return/branch next-PC select.
// All state moves on the falling CLK edge; define PC_RAS_EN to add the circular return-address stack.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      INC       = 4,
    parameter int unsigned      IMM_SHIFT = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             MasterReset_L,
    input  logic [WIDTH-1:0] startPC,
    input  logic [WIDTH-1:0] imm32,
    input  logic             nPC_Sel,
    input  logic             zero,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] PC,
    output logic             pc_valid,
    output logic             redirect,
    output logic             ras_underflow
);

    typedef enum logic [1:0] {ST_RESET, ST_LOAD, ST_RUN, ST_HALT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc_nxt, pc_seq, pc_branch, ras_top;
    logic             redirect_nxt, run_go, ret_hit, ret_miss;

    assign pc_seq    = PC + WIDTH'(INC);
    assign pc_branch = pc_seq + (imm32 << IMM_SHIFT);
    // run_go: a RUN cycle that actually advances the PC (not halting, not stalled)
    assign run_go    = (state == ST_RUN) && !halt && !stall;
    assign pc_valid  = (state == ST_RUN) && !stall;

`ifdef PC_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_sp, ras_top_idx;
    logic [PW:0]      ras_cnt;
    logic             ras_push;

    // ras_sp points at the next free slot; wrapping it overwrites the oldest entry
    assign ras_top_idx = ras_sp - PW'(1);
    assign ras_top     = ras_mem[ras_top_idx];
    assign ras_push    = run_go && call;
    assign ret_hit     = run_go && !jump && !call && ret && (ras_cnt != '0);
    assign ret_miss    = run_go && !jump && !call && ret && (ras_cnt == '0);

    always_ff @(negedge CLK or negedge MasterReset_L) begin
        if (!MasterReset_L) begin
            ras_sp        <= '0;
            ras_cnt       <= '0;
            ras_underflow <= 1'b0;
        end else begin
            if (ras_push) begin
                ras_sp <= ras_sp + PW'(1);
                if (ras_cnt != (PW+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (PW+1)'(1);
            end else if (ret_hit) begin
                ras_sp  <= ras_top_idx;
                ras_cnt <= ras_cnt - (PW+1)'(1);
            end
            if (ret_miss) ras_underflow <= 1'b1;
        end
    end

    always_ff @(negedge CLK) begin
        if (ras_push) ras_mem[ras_sp] <= pc_seq;
    end
`else
    logic unused_ret;

    assign unused_ret    = ret;
    assign ras_top       = '0;
    assign ret_hit       = 1'b0;
    assign ret_miss      = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_ff @(negedge CLK or negedge MasterReset_L) begin
        if (!MasterReset_L) begin
            state    <= ST_RESET;
            PC       <= RESET_VEC;
            redirect <= 1'b0;
        end else begin
            state    <= state_nxt;
            PC       <= pc_nxt;
            redirect <= redirect_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = PC;
        redirect_nxt = 1'b0;
        case (state)
            ST_RESET: state_nxt = ST_LOAD;
            ST_LOAD: begin
                pc_nxt    = startPC;
                state_nxt = ST_RUN;
            end
            ST_HALT: if (resume) state_nxt = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_HALT;
                end else if (!stall) begin
                    if (jump || call) begin
                        pc_nxt       = jump_target;
                        redirect_nxt = 1'b1;
                    end else if (ret_hit) begin
                        pc_nxt       = ras_top;
                        redirect_nxt = 1'b1;
                    end else if (ret_miss) begin
                        pc_nxt = pc_seq;
                    end else if (nPC_Sel && zero) begin
                        pc_nxt       = pc_branch;
                        redirect_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc_seq;
                    end
                end
            end
            default: state_nxt = ST_RESET;
        endcase
    end

endmodule
